// File: rtl/reg_scoreboard_if.sv
// Issue/write-back bundle between decode, write-back and the register scoreboard.
// The master side (decode/write-back) drives requests; the slave (scoreboard) returns status.
interface reg_scoreboard_if #(
  parameter int NREG = 32,
  parameter int AW   = 5
);
  logic            issue_valid;
  logic [AW-1:0]   issue_rs;
  logic [AW-1:0]   issue_rt;
  logic            uses_rs;
  logic            uses_rt;
  logic            issue_wr_en;
  logic [AW-1:0]   issue_rd;
  logic            wb_en;
  logic [AW-1:0]   wb_rd;
  logic            stall;
  logic [NREG-1:0] pending;
  logic [AW:0]     pend_cnt;
  logic            err;

  modport master (
    output issue_valid, issue_rs, issue_rt, uses_rs, uses_rt,
    output issue_wr_en, issue_rd, wb_en, wb_rd,
    input  stall, pending, pend_cnt, err
  );

  modport slave (
    input  issue_valid, issue_rs, issue_rt, uses_rs, uses_rt,
    input  issue_wr_en, issue_rd, wb_en, wb_rd,
    output stall, pending, pend_cnt, err
  );
endinterface

// File: rtl/reg_scoreboard.sv
// Register scoreboard: tracks in-flight register writes and stalls issue on RAW/WAW
// hazards, with a same-cycle write-back bypass through the write-through register file.
module reg_scoreboard #(
  parameter int NREG = 32,
  parameter int AW   = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  reg_scoreboard_if.slave sb
);
  logic [NREG-1:0] pending_reg;
  logic [NREG-1:0] pending_next;
  logic [AW:0]     cnt_reg;
  logic [AW:0]     cnt_next;
  logic            err_reg;

  logic rs_haz, rt_haz, waw_haz;
  logic accept, set_en, clr_en, wb_bad;
  logic [NREG-1:0] set_mask, clr_mask;

  // A source matching this cycle's write-back is read through the register file.
  always_comb begin
    rs_haz  = sb.uses_rs && (sb.issue_rs != '0) && pending_reg[sb.issue_rs]
              && !(sb.wb_en && (sb.wb_rd == sb.issue_rs));
    rt_haz  = sb.uses_rt && (sb.issue_rt != '0) && pending_reg[sb.issue_rt]
              && !(sb.wb_en && (sb.wb_rd == sb.issue_rt));
    waw_haz = sb.issue_wr_en && (sb.issue_rd != '0) && pending_reg[sb.issue_rd]
              && !(sb.wb_en && (sb.wb_rd == sb.issue_rd));
    sb.stall = sb.issue_valid && (rs_haz || rt_haz || waw_haz);
    accept   = sb.issue_valid && !sb.stall;
    set_en   = accept && sb.issue_wr_en && (sb.issue_rd != '0);
    clr_en   = sb.wb_en && (sb.wb_rd != '0) && pending_reg[sb.wb_rd];
    wb_bad   = sb.wb_en && (sb.wb_rd != '0) && !pending_reg[sb.wb_rd];
    cnt_next = cnt_reg + {{AW{1'b0}}, set_en} - {{AW{1'b0}}, clr_en};
  end

  // Set wins over clear on the same register, so a WAW-bypassed reissue stays pending.
  generate
    for (genvar gi = 0; gi < NREG; gi++) begin : g_bit
      assign set_mask[gi]     = set_en && (sb.issue_rd == AW'(gi));
      assign clr_mask[gi]     = clr_en && (sb.wb_rd == AW'(gi));
      assign pending_next[gi] = (pending_reg[gi] && !clr_mask[gi]) || set_mask[gi];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_reg <= '0;
      cnt_reg     <= '0;
      err_reg     <= 1'b0;
    end else begin
      pending_reg <= pending_next;
      cnt_reg     <= cnt_next;
      if (wb_bad)
        err_reg <= 1'b1;
    end
  end

  assign sb.pending  = pending_reg;
  assign sb.pend_cnt = cnt_reg;
  assign sb.err      = err_reg;
endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard: reset, zero register, RAW/WAW hazards with bypass,
// write-back error, fill/drain and asynchronous reset mid-drain.
module tb_reg_scoreboard;
  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  reg_scoreboard_if #(.NREG(32), .AW(5)) sb ();

  reg_scoreboard #(.NREG(32), .AW(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sb    (sb.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %-14s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    sb.issue_valid = 0; sb.issue_rs = 0; sb.issue_rt = 0;
    sb.uses_rs = 0; sb.uses_rt = 0; sb.issue_wr_en = 0; sb.issue_rd = 0;
    sb.wb_en = 0; sb.wb_rd = 0;
  endtask

  task automatic issue(input logic [4:0] rs, input logic urs, input logic [4:0] rt,
                       input logic urt, input logic wr, input logic [4:0] rd);
    sb.issue_valid = 1; sb.issue_rs = rs; sb.uses_rs = urs;
    sb.issue_rt = rt; sb.uses_rt = urt; sb.issue_wr_en = wr; sb.issue_rd = rd;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    idle();
    rst_n = 0;
    #2;
    check("rst_pending", 64'(sb.pending), 64'h0);
    check("rst_cnt", 64'(sb.pend_cnt), 64'd0);
    check("rst_err", 64'(sb.err), 64'd0);
    check("rst_stall", 64'(sb.stall), 64'd0);
    tick();
    tick();
    rst_n = 1;

    // Zero register: never stalls, never becomes pending
    tick();
    issue(5'd0, 1, 5'd0, 0, 1, 5'd0);
    #1 check("r0_stall", 64'(sb.stall), 64'd0);
    tick();
    check("r0_pending", 64'(sb.pending), 64'h0);
    check("r0_cnt", 64'(sb.pend_cnt), 64'd0);

    // RAW stall and bypass release
    issue(5'd0, 0, 5'd0, 0, 1, 5'd8);
    tick();
    check("raw_set_pend", 64'(sb.pending), 64'h100);
    check("raw_set_cnt", 64'(sb.pend_cnt), 64'd1);
    issue(5'd8, 1, 5'd0, 0, 0, 5'd0);
    #1 check("raw_stall", 64'(sb.stall), 64'd1);
    tick();
    check("raw_stall_hold", 64'(sb.stall), 64'd1);
    tick();
    sb.wb_en = 1; sb.wb_rd = 5'd8;
    #1 check("raw_bypass", 64'(sb.stall), 64'd0);
    tick();
    idle();
    check("raw_clr_pend", 64'(sb.pending), 64'h0);
    check("raw_clr_cnt", 64'(sb.pend_cnt), 64'd0);

    // WAW stall; same-cycle write-back lets the reissue through and bit stays set
    issue(5'd0, 0, 5'd0, 0, 1, 5'd9);
    tick();
    issue(5'd0, 0, 5'd0, 0, 1, 5'd9);
    #1 check("waw_stall", 64'(sb.stall), 64'd1);
    sb.wb_en = 1; sb.wb_rd = 5'd9;
    #1 check("waw_bypass", 64'(sb.stall), 64'd0);
    tick();
    idle();
    check("waw_pend", 64'(sb.pending), 64'h200);
    check("waw_cnt", 64'(sb.pend_cnt), 64'd1);
    check("waw_err", 64'(sb.err), 64'd0);

    // Unused sources and invalid issue are ignored
    issue(5'd0, 0, 5'd0, 0, 1, 5'd3);
    tick();
    check("r3_pend", 64'(sb.pending), 64'h208);
    issue(5'd0, 0, 5'd3, 0, 0, 5'd0);
    #1 check("unused_rt", 64'(sb.stall), 64'd0);
    sb.uses_rt = 1;
    #1 check("used_rt", 64'(sb.stall), 64'd1);
    sb.issue_valid = 0;
    #1 check("invalid_issue", 64'(sb.stall), 64'd0);
    tick();
    idle();

    // Write-back to r0 is silent; to a non-pending register it is a sticky error
    sb.wb_en = 1; sb.wb_rd = 5'd0;
    tick();
    check("wb_r0_err", 64'(sb.err), 64'd0);
    sb.wb_rd = 5'd12;
    #1 check("wb12_err_pre", 64'(sb.err), 64'd0);
    tick();
    idle();
    check("wb12_err", 64'(sb.err), 64'd1);
    check("wb12_cnt", 64'(sb.pend_cnt), 64'd2);
    tick();
    check("err_sticky", 64'(sb.err), 64'd1);

    // Read-and-write the same non-pending register
    issue(5'd5, 1, 5'd0, 0, 1, 5'd5);
    #1 check("addi_stall", 64'(sb.stall), 64'd0);
    tick();
    idle();
    check("addi_pend", 64'(sb.pending), 64'h228);
    check("addi_cnt", 64'(sb.pend_cnt), 64'd3);

    // Asynchronous reset between edges clears everything at once
    #2 rst_n = 0;
    #1;
    check("arst_pend", 64'(sb.pending), 64'h0);
    check("arst_cnt", 64'(sb.pend_cnt), 64'd0);
    check("arst_err", 64'(sb.err), 64'd0);
    #1 rst_n = 1;
    tick();

    // Fill all 31 writable registers back to back
    for (int i = 1; i < 32; i++) begin
      issue(5'd0, 0, 5'd0, 0, 1, 5'(i));
      tick();
    end
    idle();
    check("fill_cnt", 64'(sb.pend_cnt), 64'd31);
    check("fill_pend", 64'(sb.pending), 64'hFFFF_FFFE);
    issue(5'd31, 1, 5'd1, 1, 0, 5'd0);
    #1 check("fill_stall", 64'(sb.stall), 64'd1);
    idle();

    // Retire all 31
    for (int i = 1; i < 32; i++) begin
      sb.wb_en = 1; sb.wb_rd = 5'(i);
      tick();
    end
    idle();
    check("drain_cnt", 64'(sb.pend_cnt), 64'd0);
    check("drain_pend", 64'(sb.pending), 64'h0);
    check("drain_err", 64'(sb.err), 64'd0);

    // Refill, partially drain, then reset mid-drain
    for (int i = 1; i < 32; i++) begin
      issue(5'd0, 0, 5'd0, 0, 1, 5'(i));
      tick();
    end
    idle();
    for (int i = 1; i <= 20; i++) begin
      sb.wb_en = 1; sb.wb_rd = 5'(i);
      tick();
    end
    check("part_cnt", 64'(sb.pend_cnt), 64'd11);
    check("part_pend", 64'(sb.pending), 64'hFFE0_0000);
    sb.wb_rd = 5'd21;
    issue(5'd25, 1, 5'd0, 0, 0, 5'd0);
    #2 rst_n = 0;
    #1;
    check("mid_rst_pend", 64'(sb.pending), 64'h0);
    check("mid_rst_cnt", 64'(sb.pend_cnt), 64'd0);
    check("mid_rst_err", 64'(sb.err), 64'd0);
    check("mid_rst_stall", 64'(sb.stall), 64'd0);
    idle();
    tick();
    rst_n = 1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
